// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-loads the 256-word memory from a byte stream,
// then runs the PC fetch loop into a registered valid/ready stage toward decode.
module imem_fetch_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    input  logic                  load_last,
    output logic                  load_busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_inst,
    input  logic                  run_start,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [31:0]           inst_pc,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_byte_cnt_p0;
    logic [ADDR_WIDTH-1:0] r_word_cnt_p0;
    logic [DATA_WIDTH-1:0] r_asm_p0;
    logic                  r_load_done;
    logic                  r_wr_vld_p1;
    logic [ADDR_WIDTH-1:0] r_wr_addr_p1;
    logic [DATA_WIDTH-1:0] r_wr_data_p1;

    logic [31:0]           r_pc_p0;
    logic                  r_inst_vld_p1;
    logic [DATA_WIDTH-1:0] r_inst_data_p1;
    logic [31:0]           r_inst_pc_p1;

    logic                  w_idle_or_halt;
    logic                  w_start_load;
    logic                  w_start_run;
    logic                  w_byte_acc;
    logic                  w_word_wr;
    logic                  w_final_wr;
    logic [DATA_WIDTH-1:0] w_asm_nxt;
    logic                  w_halt;
    logic                  w_redirect;
    logic                  w_capture;

    assign w_idle_or_halt = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_start_load   = w_idle_or_halt && load_start;
    assign w_start_run    = w_idle_or_halt && run_start && !load_start;

    // Once the closing write is issued, the remaining LOAD cycle ignores bytes.
    assign w_byte_acc = (r_state == S_LOAD) && !r_load_done && load_valid;
    assign w_word_wr  = w_byte_acc && ((r_byte_cnt_p0 == 2'd3) || load_last);
    assign w_final_wr = w_word_wr && (load_last || (r_word_cnt_p0 == {ADDR_WIDTH{1'b1}}));
    assign w_asm_nxt  = r_asm_p0 | (DATA_WIDTH'(load_data) << {r_byte_cnt_p0, 3'b000});

    assign w_halt     = (r_state == S_RUN) && halt;
    assign w_redirect = (r_state == S_RUN) && redirect_valid && !halt;
    assign w_capture  = (r_state == S_RUN) && !halt && !redirect_valid &&
                        (!r_inst_vld_p1 || inst_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (load_start)
                    w_state_nxt = S_LOAD;
                else if (run_start)
                    w_state_nxt = S_RUN;
            end
            S_LOAD: begin
                if (r_load_done)
                    w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (halt)
                    w_state_nxt = S_HALT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: byte assembly feeding the registered memory write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt_p0 <= 2'd0;
            r_word_cnt_p0 <= '0;
            r_asm_p0      <= '0;
            r_load_done   <= 1'b0;
            r_wr_vld_p1   <= 1'b0;
            r_wr_addr_p1  <= '0;
            r_wr_data_p1  <= '0;
        end else begin
            r_wr_vld_p1 <= w_word_wr;
            if (w_start_load) begin
                r_byte_cnt_p0 <= 2'd0;
                r_word_cnt_p0 <= '0;
                r_asm_p0      <= '0;
                r_load_done   <= 1'b0;
            end else if (w_word_wr) begin
                r_wr_addr_p1  <= r_word_cnt_p0;
                r_wr_data_p1  <= w_asm_nxt;
                r_word_cnt_p0 <= r_word_cnt_p0 + ADDR_WIDTH'(1);
                r_byte_cnt_p0 <= 2'd0;
                r_asm_p0      <= '0;
                r_load_done   <= w_final_wr;
            end else if (w_byte_acc) begin
                r_asm_p0      <= w_asm_nxt;
                r_byte_cnt_p0 <= r_byte_cnt_p0 + 2'd1;
            end
        end
    end

    // Stage p0 -> p1: PC drives the read address, fetched word lands in the decode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pc_p0        <= RESET_PC;
            r_inst_vld_p1  <= 1'b0;
            r_inst_data_p1 <= '0;
            r_inst_pc_p1   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_run) begin
                r_pc_p0       <= RESET_PC;
                r_inst_vld_p1 <= 1'b0;
            end else if (w_halt) begin
                r_inst_vld_p1 <= 1'b0;
            end else if (w_redirect) begin
                r_pc_p0       <= redirect_pc & ~32'd3;
                r_inst_vld_p1 <= 1'b0;
            end else if (w_capture) begin
                r_inst_data_p1 <= imem_inst;
                r_inst_pc_p1   <= r_pc_p0;
                r_inst_vld_p1  <= 1'b1;
                r_pc_p0        <= r_pc_p0 + 32'd4;
            end
        end
    end

    assign load_busy  = (r_state == S_LOAD);
    assign mem_we     = r_wr_vld_p1;
    assign mem_waddr  = r_wr_addr_p1;
    assign mem_wdata  = r_wr_data_p1;
    assign imem_addr  = r_pc_p0[ADDR_WIDTH+1:2];
    assign inst_valid = r_inst_vld_p1;
    assign inst_out   = r_inst_data_p1;
    assign inst_pc    = r_inst_pc_p1;
    assign state_o    = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: boot-load, fetch stream, stall,
// redirect, halt and reset scenarios against a behavioural reference model.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_last = 1'b0;
    logic        load_busy;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst;
    logic        run_start = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [1:0]  state_o;

    logic [31:0] mem [256];
    logic [31:0] img [256];
    logic [39:0] wr_q [$];
    logic [7:0]  byte_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    imem_fetch_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_busy(load_busy),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .run_start(run_start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Instruction memory model and write monitor.
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign imem_inst = mem[imem_addr];
    always @(negedge clk) if (mem_we) wr_q.push_back({mem_waddr, mem_wdata});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int gap_pct);
        int          nb;
        int          nw;
        logic [31:0] w;
        nb = byte_q.size();
        wr_q.delete();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_vec++;
        if (state_o !== 2'd1 || load_busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_enter: state=%0d busy=%0b, required state=1 busy=1", state_o, load_busy);
        end
        for (int i = 0; i < nb; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                load_valid = 1'b0;
                load_data  = 8'($urandom);
                load_last  = 1'($urandom_range(1));
                step();
            end
            load_valid = 1'b1;
            load_data  = byte_q[i];
            load_last  = (i == nb - 1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        for (int k = 0; k < 8 && state_o !== 2'd0; k++) step();
        n_vec++;
        if (state_o !== 2'd0) begin
            n_err++;
            $display("FAIL load_exit: state=%0d, required 0 within 8 cycles", state_o);
        end
        nw = (nb + 3) / 4;
        if (nw > 256) nw = 256;
        n_vec++;
        if (wr_q.size() != nw) begin
            n_err++;
            $display("FAIL load_count: writes=%0d, required %0d", wr_q.size(), nw);
        end
        for (int wi = 0; wi < nw; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * wi + k < nb) w = w | (32'(byte_q[4 * wi + k]) << (8 * k));
            img[wi] = w;
            if (wi < wr_q.size()) begin
                n_vec++;
                if (wr_q[wi] !== {8'(wi), w}) begin
                    n_err++;
                    $display("FAIL load_word%0d: addr/data=%h, required %h", wi, wr_q[wi], {8'(wi), w});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({load_busy, mem_we, mem_waddr, mem_wdata, imem_addr, inst_valid, inst_out, inst_pc, state_o} !== '0) begin
            n_err++;
            $display("FAIL reset_held: outputs=%h, required all 0",
                     {load_busy, mem_we, mem_waddr, mem_wdata, imem_addr, inst_valid, inst_out, inst_pc, state_o});
        end
        rst = 1'b0;
        step();
        n_vec++;
        if ({load_busy, mem_we, inst_valid, imem_addr, state_o} !== '0) begin
            n_err++;
            $display("FAIL reset_release: busy=%0b we=%0b vld=%0b addr=%0d state=%0d, required all 0",
                     load_busy, mem_we, inst_valid, imem_addr, state_o);
        end
    endtask

    task automatic test_load_basic();
        logic [7:0]  bl [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        logic        exp_we;
        logic [7:0]  exp_a;
        logic [31:0] exp_d;
        wr_q.delete();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = bl[i];
            load_last  = (i == 7);
            step();
            exp_we = (i == 3) || (i == 7);
            exp_a  = (i == 3) ? 8'd0 : 8'd1;
            exp_d  = (i == 3) ? 32'h00500013 : 32'h00100093;
            n_vec++;
            if (mem_we !== exp_we || state_o !== 2'd1 ||
                (exp_we && (mem_waddr !== exp_a || mem_wdata !== exp_d))) begin
                n_err++;
                $display("FAIL load_basic_b%0d: we=%0b state=%0d addr=%0d data=%h, required we=%0b state=1 addr=%0d data=%h",
                         i, mem_we, state_o, mem_waddr, mem_wdata, exp_we, exp_a, exp_d);
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        n_vec++;
        if (state_o !== 2'd0 || mem_we !== 1'b0 || load_busy !== 1'b0 || wr_q.size() != 2) begin
            n_err++;
            $display("FAIL load_basic_exit: state=%0d we=%0b busy=%0b writes=%0d, required 0/0/0/2",
                     state_o, mem_we, load_busy, wr_q.size());
        end
    endtask

    task automatic test_load_partial();
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load_image(0);
        if (wr_q.size() == 2) begin
            n_vec++;
            if (wr_q[0][31:0] !== 32'h04030201 || wr_q[1][31:0] !== 32'h00000605) begin
                n_err++;
                $display("FAIL load_partial: w0=%h w1=%h, required 04030201 00000605", wr_q[0][31:0], wr_q[1][31:0]);
            end
        end
    endtask

    task automatic test_load_random();
        for (int r = 0; r < 4; r++) begin
            byte_q.delete();
            for (int i = 0; i < 1 + $urandom_range(39); i++) byte_q.push_back(8'($urandom));
            load_image(30);
        end
    endtask

    task automatic test_load_full();
        byte_q.delete();
        for (int i = 0; i < 1030; i++) byte_q.push_back(8'($urandom));
        load_image(10);
    endtask

    task automatic test_run_stream();
        inst_ready = 1'b1;
        run_start  = 1'b1;
        step();
        run_start  = 1'b0;
        n_vec++;
        if (state_o !== 2'd2 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL run_enter: state=%0d vld=%0b, required 2/0", state_o, inst_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_out !== img[k]) begin
                n_err++;
                $display("FAIL run_stream%0d: vld=%0b pc=%h inst=%h, required 1 %h %h",
                         k, inst_valid, inst_pc, inst_out, 32'(4 * k), img[k]);
            end
        end
    endtask

    task automatic test_stall();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_vec++;
        if (state_o !== 2'd3 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_halt: state=%0d vld=%0b, required 3/0", state_o, inst_valid);
        end
        inst_ready = 1'b1;
        run_start  = 1'b1;
        step();
        run_start  = 1'b0;
        step();
        step();
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
            n_err++;
            $display("FAIL stall_pre: vld=%0b pc=%h, required 1 00000004", inst_valid, inst_pc);
        end
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_out !== img[1] || imem_addr !== 8'd2) begin
                n_err++;
                $display("FAIL stall_hold%0d: vld=%0b pc=%h inst=%h addr=%0d, required 1 00000004 %h 2",
                         k, inst_valid, inst_pc, inst_out, imem_addr, img[1]);
            end
        end
        inst_ready = 1'b1;
        step();
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_out !== img[2]) begin
            n_err++;
            $display("FAIL stall_release: vld=%0b pc=%h inst=%h, required 1 00000008 %h",
                     inst_valid, inst_pc, inst_out, img[2]);
        end
    endtask

    task automatic test_redirect();
        inst_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h23;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b0 || imem_addr !== 8'd8) begin
            n_err++;
            $display("FAIL redirect_bubble: vld=%0b addr=%0d, required 0 8", inst_valid, imem_addr);
        end
        step();
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst_out !== img[8]) begin
            n_err++;
            $display("FAIL redirect_target: vld=%0b pc=%h inst=%h, required 1 00000020 %h",
                     inst_valid, inst_pc, inst_out, img[8]);
        end
    endtask

    task automatic test_halt_redirect();
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        halt           = 1'b0;
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (state_o !== 2'd3 || inst_valid !== 1'b0 || imem_addr !== 8'd9) begin
                n_err++;
                $display("FAIL halt_redirect%0d: state=%0d vld=%0b addr=%0d, required 3 0 9",
                         k, state_o, inst_valid, imem_addr);
            end
            step();
        end
        inst_ready = 1'b1;
        run_start  = 1'b1;
        step();
        run_start  = 1'b0;
        step();
        n_vec++;
        if (state_o !== 2'd2 || inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== img[0]) begin
            n_err++;
            $display("FAIL halt_restart: state=%0d vld=%0b pc=%h inst=%h, required 2 1 00000000 %h",
                     state_o, inst_valid, inst_pc, inst_out, img[0]);
        end
    endtask

    task automatic test_random_run();
        logic        m_valid;
        logic [31:0] m_pc;
        logic [31:0] m_out_pc;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        halt = 1'b1;
        step();
        halt      = 1'b0;
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        m_valid   = 1'b0;
        m_pc      = 32'h0;
        m_out_pc  = 32'h0;
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(9) < 7);
            rv  = ($urandom_range(9) == 0);
            case ($urandom_range(2))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFFFFF0 | 32'($urandom_range(15));
                default: rpc = 32'($urandom_range(1023));
            endcase
            inst_ready     = rdy;
            redirect_valid = rv;
            redirect_pc    = rpc;
            step();
            // Decode-side view: a redirect flushes, otherwise a free slot takes the next PC.
            if (rv) begin
                m_valid = 1'b0;
                m_pc    = rpc & 32'hFFFFFFFC;
            end else if (!m_valid || rdy) begin
                m_valid  = 1'b1;
                m_out_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
            n_vec++;
            if (inst_valid !== m_valid || imem_addr !== m_pc[9:2] || state_o !== 2'd2 ||
                (m_valid && (inst_pc !== m_out_pc || inst_out !== img[m_out_pc[9:2]]))) begin
                n_err++;
                $display("FAIL random_run c%0d: vld=%0b pc=%h inst=%h addr=%0d, required %0b %h %h %0d",
                         c, inst_valid, inst_pc, inst_out, imem_addr, m_valid, m_out_pc,
                         img[m_out_pc[9:2]], m_pc[9:2]);
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_midload();
        halt = 1'b1;
        step();
        halt = 1'b0;
        inst_ready = 1'b0;
        wr_q.delete();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hAA;
        step();
        load_data  = 8'hBB;
        step();
        load_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({load_busy, mem_we, mem_waddr, mem_wdata, imem_addr, inst_valid, inst_out, inst_pc, state_o} !== '0) begin
            n_err++;
            $display("FAIL reset_midload: outputs=%h, required all 0",
                     {load_busy, mem_we, mem_waddr, mem_wdata, imem_addr, inst_valid, inst_out, inst_pc, state_o});
        end
        step();
        rst = 1'b0;
        step();
        n_vec++;
        if (wr_q.size() != 0 || state_o !== 2'd0) begin
            n_err++;
            $display("FAIL reset_midload_nowrite: writes=%0d state=%0d, required 0 0", wr_q.size(), state_o);
        end
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_image(0);
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_partial();
        test_load_random();
        test_load_full();
        test_run_stream();
        test_stall();
        test_redirect();
        test_halt_redirect();
        test_random_run();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
